// File: rtl/load_store_unit.sv
// Memory stage behind the integer ALU: one data-bus transaction per accepted
// request, with store lane steering, load extraction and fault detection.
module load_store_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_load,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_strb,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            st_done,
  output logic            fault,
  output logic [1:0]      fault_cause
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic            is_load_q;

  logic            illegal;
  logic            misaligned;
  logic [1:0]      size;
  logic [1:0]      off;
  logic [3:0]      strb_n;
  logic [XLEN-1:0] wdata_n;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;

  // Request decode: legality, alignment and store lane steering.
  always_comb begin
    size       = req_funct3[1:0];
    off        = req_addr[1:0];
    illegal    = 1'b0;
    misaligned = 1'b0;
    strb_n     = '0;
    wdata_n    = '0;

    if (req_load == req_store) begin
      illegal = 1'b1;
    end else if (req_load) begin
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end else begin
      illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end

    misaligned = ((size == 2'b01) && off[0]) ||
                 ((size == 2'b10) && (off != 2'b00));

    if (req_store) begin
      case (size)
        2'b00: begin
          strb_n  = 4'b0001 << off;
          wdata_n = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          strb_n  = 4'b0011 << off;
          wdata_n = {2{req_wdata[15:0]}};
        end
        default: begin
          strb_n  = 4'b1111;
          wdata_n = req_wdata;
        end
      endcase
    end
  end

  // Load extraction from the returned word using the registered offset/size.
  always_comb begin
    shifted  = bus_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (f3_q)
      3'b000:  load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      is_load_q   <= 1'b0;
      req_ready   <= 1'b1;
      bus_valid   <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_strb    <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      st_done     <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= '0;
    end else begin
      fault       <= 1'b0;
      fault_cause <= '0;
      st_done     <= 1'b0;
      wb_valid    <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            rd_q      <= req_rd;
            is_load_q <= req_load;
            if (illegal) begin
              fault       <= 1'b1;
              fault_cause <= 2'b10;
            end else if (misaligned) begin
              fault       <= 1'b1;
              fault_cause <= 2'b01;
            end else begin
              state     <= REQ;
              req_ready <= 1'b0;
              bus_valid <= 1'b1;
              bus_we    <= req_store;
              bus_addr  <= {req_addr[XLEN-1:2], 2'b00};
              bus_wdata <= wdata_n;
              bus_strb  <= strb_n;
            end
          end
        end

        REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (is_load_q) begin
              state <= WAIT;
            end else begin
              state     <= IDLE;
              st_done   <= 1'b1;
              req_ready <= 1'b1;
            end
          end
        end

        WAIT: begin
          if (bus_rvalid) begin
            wb_data  <= load_ext;
            wb_rd    <= rd_q;
            wb_valid <= 1'b1;
            state    <= RESP;
          end
        end

        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a behavioural model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done;
  logic        fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_strb(bus_strb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  localparam logic [112:0] RESET_VEC = {1'b1, 112'b0};

  function automatic logic [112:0] out_vec();
    return {req_ready, bus_valid, bus_we, bus_addr, bus_wdata, bus_strb,
            wb_valid, wb_rd, wb_data, st_done, fault, fault_cause};
  endfunction

  function automatic logic [1:0] exp_cause(input logic ld, input logic st,
                                           input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int nbytes;
    if (ld == st) return 2'b10;
    if (ld) legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else    legal = f3 inside {3'b000, 3'b001, 3'b010};
    if (!legal) return 2'b10;
    nbytes = 1 << f3[1:0];
    if ((int'(a[1:0]) % nbytes) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    int nbytes;
    int o;
    s = '0;
    nbytes = 1 << f3[1:0];
    o = int'(a[1:0]);
    for (int i = 0; i < nbytes; i++) s[o + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int nbytes;
    nbytes = 1 << f3[1:0];
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % nbytes) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] v;
    logic [31:0] mask;
    int nbytes;
    nbytes = 1 << f3[1:0];
    if (nbytes == 4) return word;
    v = word >> (8 * int'(a[1:0]));
    mask = (32'd1 << (8 * nbytes)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8*nbytes-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation from request to its terminal event, checked cycle by cycle.
  task automatic run_op(input string nm, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input int rdy_dly, input int rv_dly,
                        input logic [31:0] rdata);
    logic [1:0]  cause;
    logic [31:0] exp_data;
    logic [3:0]  strb;
    cause = exp_cause(ld, st, f3, a);
    strb  = st ? exp_strb(f3, a) : 4'b0000;

    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready_at_issue: got %b want 1", nm, req_ready);
    end
    req_valid  = 1'b1;
    req_load   = ld;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
    step();
    req_valid  = 1'b0;
    req_load   = 1'($urandom);
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;

    if (cause != 2'b00) begin
      checks++;
      if ({fault, fault_cause, bus_valid, req_ready} !== {1'b1, cause, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL %s fault: got fault=%b cause=%b bus_valid=%b req_ready=%b want 1 %b 0 1",
                 nm, fault, fault_cause, bus_valid, req_ready, cause);
      end
      return;
    end

    checks++;
    if ({fault, fault_cause} !== 3'b000) begin
      errors++;
      $display("FAIL %s no_fault: got fault=%b cause=%b want 0 00", nm, fault, fault_cause);
    end

    for (int k = 0; k <= rdy_dly; k++) begin
      checks++;
      if ({bus_valid, bus_we, bus_addr, bus_strb, req_ready, st_done, wb_valid} !==
          {1'b1, st, a & 32'hFFFF_FFFC, strb, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s bus_req cyc%0d: got v=%b we=%b addr=%h strb=%b rdy=%b sd=%b wbv=%b want 1 %b %h %b 0 0 0",
                 nm, k, bus_valid, bus_we, bus_addr, bus_strb, req_ready, st_done, wb_valid,
                 st, a & 32'hFFFF_FFFC, strb);
      end
      if (st) begin
        checks++;
        if (bus_wdata !== exp_wdata(f3, wd)) begin
          errors++;
          $display("FAIL %s bus_wdata cyc%0d: got %h want %h", nm, k, bus_wdata, exp_wdata(f3, wd));
        end
      end
      bus_ready  = (k == rdy_dly);
      bus_rvalid = 1'($urandom);
      bus_rdata  = $urandom;
      step();
    end
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;

    if (st) begin
      checks++;
      if ({st_done, bus_valid, req_ready} !== 3'b101) begin
        errors++;
        $display("FAIL %s st_done: got sd=%b bus_valid=%b req_ready=%b want 1 0 1",
                 nm, st_done, bus_valid, req_ready);
      end
      return;
    end

    for (int k = 0; k <= rv_dly; k++) begin
      checks++;
      if ({wb_valid, bus_valid, req_ready} !== 3'b000) begin
        errors++;
        $display("FAIL %s wait cyc%0d: got wbv=%b bus_valid=%b req_ready=%b want 0 0 0",
                 nm, k, wb_valid, bus_valid, req_ready);
      end
      bus_rvalid = (k == rv_dly);
      bus_rdata  = (k == rv_dly) ? rdata : $urandom;
      step();
    end
    bus_rvalid = 1'b0;
    bus_rdata  = $urandom;

    exp_data = exp_load(f3, a, rdata);
    checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, rd, exp_data}) begin
      errors++;
      $display("FAIL %s wb: got v=%b rd=%0d data=%h want 1 %0d %h", nm, wb_valid, wb_rd, wb_data,
               rd, exp_data);
    end
    step();
    checks++;
    if ({wb_valid, req_ready, wb_rd, wb_data} !== {1'b0, 1'b1, rd, exp_data}) begin
      errors++;
      $display("FAIL %s wb_after: got v=%b rdy=%b rd=%0d data=%h want 0 1 %0d %h", nm, wb_valid,
               req_ready, wb_rd, wb_data, rd, exp_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    step();
    step();
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", out_vec(), RESET_VEC);
    end
    rst = 1'b0;
    step();
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL after_reset_idle: got %h want %h", out_vec(), RESET_VEC);
    end
  endtask

  task automatic test_store();
    run_op("sw_0x100", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0);
    run_op("sb_0x103", 1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0, 0, 0, 32'h0);
    run_op("sh_0x102", 1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 5'd0, 1, 0, 32'h0);
  endtask

  task automatic test_load();
    run_op("lb_0x202", 1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 5'd7, 0, 3, 32'h12F45678);
    run_op("lbu_0x202", 1'b1, 1'b0, 3'b100, 32'h202, 32'h0, 5'd9, 0, 3, 32'h12F45678);
    run_op("lh_0x202", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 5'd3, 0, 0, 32'h8001_0000);
    run_op("lhu_0x200", 1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 5'd4, 0, 1, 32'h1234_F00D);
    run_op("lw_rd0", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 5'd0, 0, 0, 32'hCAFE_F00D);
  endtask

  task automatic test_fault();
    run_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h201, 32'h0, 5'd1, 0, 0, 32'h0);
    run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h202, 32'h0, 5'd1, 0, 0, 32'h0);
    run_op("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h200, 32'h0, 5'd1, 0, 0, 32'h0);
    run_op("sw_f3_100_mis", 1'b0, 1'b1, 3'b100, 32'h201, 32'h0, 5'd1, 0, 0, 32'h0);
    run_op("both_set", 1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 5'd1, 0, 0, 32'h0);
    run_op("neither_set", 1'b0, 1'b0, 3'b000, 32'h200, 32'h0, 5'd1, 0, 0, 32'h0);
    run_op("sh_mis", 1'b0, 1'b1, 3'b001, 32'h203, 32'h0, 5'd1, 0, 0, 32'h0);
  endtask

  task automatic test_stall();
    run_op("sw_stall5", 1'b0, 1'b1, 3'b010, 32'h300, 32'h5A5A_0F0F, 5'd0, 5, 0, 32'h0);
    run_op("lw_stall5", 1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 5'd12, 5, 2, 32'h8765_4321);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_fault", 1'b1, 1'b0, 3'b111, 32'h10, 32'h0, 5'd2, 0, 0, 32'h0);
    run_op("b2b_store", 1'b0, 1'b1, 3'b000, 32'h11, 32'h77, 5'd0, 0, 0, 32'h0);
    run_op("b2b_load", 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 5'd31, 0, 0, 32'h8000_0000);
    run_op("b2b_store2", 1'b0, 1'b1, 3'b010, 32'h14, 32'h0102_0304, 5'd0, 0, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h400; req_rd = 5'd5;
    step();
    req_valid = 1'b0;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_in_wait: got %h want %h", out_vec(), RESET_VEC);
    end
    step();
    rst = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hFFFF_FFFF;
    step();
    bus_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_vec() !== RESET_VEC) begin
        errors++;
        $display("FAIL stray_rvalid cyc%0d: got %h want %h", k, out_vec(), RESET_VEC);
      end
      step();
    end
    run_op("post_reset_lw", 1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 5'd6, 0, 0, 32'h1357_9BDF);
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a;
    logic ld, st;
    int sel;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      ld = (sel == 0) || (sel >= 2 && sel <= 5);
      st = (sel == 0) || (sel >= 6);
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) :
           (ld ? 3'($urandom_range(0, 2) + ($urandom_range(0, 1) * 4)) : 3'($urandom_range(0, 2)));
      if (f3 == 3'b110) f3 = 3'b010;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 :
                                              (f3[1:0] == 2'b01) ? {1'($urandom), 1'b0} : a[1:0];
      run_op($sformatf("rand%0d", i), ld, st, f3, a, $urandom, 5'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_fault();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
